// File: rtl/approx_err_eval_if.sv
// approx_err_eval_if: start/done handshake and result bus of the error evaluator.
// Ports: start (host->engine), busy/done status, err_cnt/sum_ed/max_ed results.
// master = evaluation host, slave = approx_err_eval engine.
interface approx_err_eval_if #(
  parameter int W = 2
);
  logic           start;
  logic           busy;
  logic           done;
  logic [2*W:0]   err_cnt;
  logic [3*W+1:0] sum_ed;
  logic [W:0]     max_ed;

  modport master (
    output start,
    input  busy, done, err_cnt, sum_ed, max_ed
  );

  modport slave (
    input  start,
    output busy, done, err_cnt, sum_ed, max_ed
  );
endinterface

// File: rtl/approx_err_eval.sv
// approx_err_eval: sweeps all operand pairs of a W-bit lower-part-OR adder (P low
//   bits OR-approximated) against the exact sum and accumulates error statistics.
// Latency: start accepted at edge 0, done pulse in cycle 2^(2W)+3; no backpressure,
//   start is ignored while busy (including the done cycle).
// Ports: clk, rst (async, active-high), bus (slave: start in; busy, done,
//   err_cnt, sum_ed, max_ed out).
// Option: define APPROX_ERR_MAX_EN to build max_ed tracking; otherwise max_ed = 0.
module approx_err_eval #(
  parameter int W = 2,
  parameter int P = 1
) (
  input  logic             clk,
  input  logic             rst,
  approx_err_eval_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SWEEP,
    S_DRAIN0,
    S_DRAIN1,
    S_DONE
  } state_t;

  state_t         state, state_nxt;
  logic [2*W-1:0] idx;
  logic           sweep_clr;
  logic           idx_inc;
  logic           pair_vld;
  logic           busy_c;
  logic           done_c;

  logic [W-1:0]   op_a, op_b;
  logic [W:0]     exact_sum, approx_sum, ed;
  logic           carry;

  logic [W:0]     s1_ed;
  logic           s1_vld;
  logic [2*W:0]   err_cnt;
  logic [3*W+1:0] sum_ed;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sweep_clr = 1'b0;
    idx_inc   = 1'b0;
    pair_vld  = 1'b0;
    busy_c    = 1'b1;
    done_c    = 1'b0;
    case (state)
      S_IDLE: begin
        busy_c = 1'b0;
        if (bus.start) begin
          sweep_clr = 1'b1;
          state_nxt = S_SWEEP;
        end
      end
      S_SWEEP: begin
        pair_vld = 1'b1;
        if (idx == {(2*W){1'b1}}) state_nxt = S_DRAIN0;
        else                      idx_inc   = 1'b1;
      end
      S_DRAIN0: state_nxt = S_DRAIN1;
      S_DRAIN1: state_nxt = S_DONE;
      S_DONE: begin
        done_c    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        busy_c    = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            idx <= '0;
    else if (sweep_clr) idx <= '0;
    else if (idx_inc)   idx <= idx + 1'b1;
  end

  // ---------------- pair models ----------------
  assign op_a      = idx[2*W-1:W];
  assign op_b      = idx[W-1:0];
  assign exact_sum = {1'b0, op_a} + {1'b0, op_b};

  // Low part: OR per bit, carry is the AND of the top approximated bit pair.
  // Upper part: plain generate/propagate ripple seeded by that carry.
  always_comb begin
    approx_sum = '0;
    carry      = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i < P) begin
        approx_sum[i] = op_a[i] | op_b[i];
        carry         = op_a[i] & op_b[i];
      end else begin
        approx_sum[i] = op_a[i] ^ op_b[i] ^ carry;
        carry         = (op_a[i] & op_b[i]) | (carry & (op_a[i] ^ op_b[i]));
      end
    end
    approx_sum[W] = carry;
  end

  assign ed = (exact_sum >= approx_sum) ? (exact_sum - approx_sum)
                                        : (approx_sum - exact_sum);

  // ---------------- stage 1 ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_ed  <= '0;
      s1_vld <= 1'b0;
    end else begin
      s1_ed  <= ed;
      s1_vld <= pair_vld;
    end
  end

  // ---------------- stage 2 accumulators ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
      sum_ed  <= '0;
    end else if (sweep_clr) begin
      err_cnt <= '0;
      sum_ed  <= '0;
    end else if (s1_vld) begin
      err_cnt <= err_cnt + {{(2*W){1'b0}}, (s1_ed != '0)};
      sum_ed  <= sum_ed + {{(2*W+1){1'b0}}, s1_ed};
    end
  end

`ifdef APPROX_ERR_MAX_EN
  logic [W:0] max_ed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           max_ed <= '0;
    else if (sweep_clr)                max_ed <= '0;
    else if (s1_vld && s1_ed > max_ed) max_ed <= s1_ed;
  end

  assign bus.max_ed = max_ed;
`else
  assign bus.max_ed = '0;
`endif

  assign bus.busy    = busy_c;
  assign bus.done    = done_c;
  assign bus.err_cnt = err_cnt;
  assign bus.sum_ed  = sum_ed;

endmodule

// File: tb/tb_approx_err_eval.sv
// tb_approx_err_eval: directed bench for approx_err_eval with three builds
// (W=2/P=1, W=2/P=0, W=3/P=1) sharing one clock and reset.
// Table-driven sweeps plus hand sequences for reset, ignored starts and held start.
module tb_approx_err_eval;

`ifdef APPROX_ERR_MAX_EN
  localparam int MX = 1;
`else
  localparam int MX = 0;
`endif

  logic clk;
  logic rst;

  approx_err_eval_if #(.W(2)) if_a ();
  approx_err_eval_if #(.W(2)) if_b ();
  approx_err_eval_if #(.W(3)) if_c ();

  approx_err_eval #(.W(2), .P(1)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  approx_err_eval #(.W(2), .P(0)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  approx_err_eval #(.W(3), .P(1)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int    sel;
    int    lat;
    int    err;
    int    sum;
    int    mx;
    string nm;
  } vec_t;

  vec_t vecs[3];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0:       if_a.start = v;
      1:       if_b.start = v;
      default: if_c.start = v;
    endcase
  endtask

  task automatic get(input int sel, output int bsy, output int dn,
                     output int e, output int s, output int m);
    case (sel)
      0: begin
        bsy = int'(if_a.busy); dn = int'(if_a.done);
        e = int'(if_a.err_cnt); s = int'(if_a.sum_ed); m = int'(if_a.max_ed);
      end
      1: begin
        bsy = int'(if_b.busy); dn = int'(if_b.done);
        e = int'(if_b.err_cnt); s = int'(if_b.sum_ed); m = int'(if_b.max_ed);
      end
      default: begin
        bsy = int'(if_c.busy); dn = int'(if_c.done);
        e = int'(if_c.err_cnt); s = int'(if_c.sum_ed); m = int'(if_c.max_ed);
      end
    endcase
  endtask

  // Called at a negedge whose cycle number is 'from'; returns the cycle in which
  // done is seen, or -1 if it never comes within the bound.
  task automatic wait_done(input int sel, input int from, output int at);
    int bsy, dn, e, s, m;
    int cyc;
    cyc = from;
    at  = -1;
    while (cyc < from + 200) begin
      get(sel, bsy, dn, e, s, m);
      if (dn != 0) begin
        at = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  // Full sweep: start accepted at edge 0; optional extra start pulses in cycles pa/pb.
  task automatic run_sweep(input int sel, input int lat, input int e_err,
                           input int e_sum, input int e_max,
                           input int pa, input int pb, input string nm);
    int bsy, dn, e, s, m;
    int cyc, busy_lo, at;
    @(negedge clk);
    set_start(sel, 1'b1);
    @(posedge clk);
    @(negedge clk);
    cyc     = 1;
    busy_lo = 0;
    at      = -1;
    while (cyc < 200) begin
      set_start(sel, (cyc == pa) || (cyc == pb));
      get(sel, bsy, dn, e, s, m);
      if (dn != 0) begin
        at = cyc;
        break;
      end
      if (bsy == 0) busy_lo++;
      @(negedge clk);
      cyc++;
    end
    check({nm, " done cycle"}, at, lat);
    check({nm, " busy gaps"}, busy_lo, 0);
    check({nm, " busy at done"}, bsy, 1);
    check({nm, " err_cnt"}, e, e_err);
    check({nm, " sum_ed"}, s, e_sum);
    check({nm, " max_ed"}, m, e_max);
    @(negedge clk);
    set_start(sel, 1'b0);
    get(sel, bsy, dn, e, s, m);
    check({nm, " done after"}, dn, 0);
    check({nm, " busy after"}, bsy, 0);
    check({nm, " err_cnt held"}, e, e_err);
  endtask

  initial begin
    int bsy, dn, e, s, m;
    int at, extra_done, extra_busy;

    vecs[0] = '{sel: 0, lat: 19, err: 4,  sum: 4,  mx: MX, nm: "w2p1"};
    vecs[1] = '{sel: 1, lat: 19, err: 0,  sum: 0,  mx: 0,  nm: "w2p0"};
    vecs[2] = '{sel: 2, lat: 67, err: 16, sum: 16, mx: MX, nm: "w3p1"};

    rst = 1'b1;
    if_a.start = 1'b0;
    if_b.start = 1'b0;
    if_c.start = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      get(i, bsy, dn, e, s, m);
      check($sformatf("reset busy %0d", i), bsy, 0);
      check($sformatf("reset done %0d", i), dn, 0);
      check($sformatf("reset err_cnt %0d", i), e, 0);
      check($sformatf("reset sum_ed %0d", i), s, 0);
      check($sformatf("reset max_ed %0d", i), m, 0);
    end
    rst = 1'b0;

    for (int i = 0; i < 3; i++)
      run_sweep(vecs[i].sel, vecs[i].lat, vecs[i].err, vecs[i].sum,
                vecs[i].mx, 0, 0, vecs[i].nm);

    // Reset in cycle 8: pair idx5 (a0=b0=1) has been accumulated by then.
    @(negedge clk);
    if_a.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if_a.start = 1'b0;
    repeat (7) @(negedge clk);
    get(0, bsy, dn, e, s, m);
    check("midsweep busy", bsy, 1);
    check("midsweep err_cnt", e, 1);
    check("midsweep sum_ed", s, 1);
    rst = 1'b1;
    #1;
    get(0, bsy, dn, e, s, m);
    check("rst busy", bsy, 0);
    check("rst err_cnt", e, 0);
    check("rst sum_ed", s, 0);
    check("rst max_ed", m, 0);
    @(negedge clk);
    rst = 1'b0;
    run_sweep(0, 19, 4, 4, MX, 0, 0, "after_rst");

    // Starts in cycle 5 (busy) and cycle 19 (done) must both be ignored.
    run_sweep(0, 19, 4, 4, MX, 5, 19, "pulses");
    extra_done = 0;
    extra_busy = 0;
    repeat (25) begin
      @(negedge clk);
      get(0, bsy, dn, e, s, m);
      extra_done += dn;
      extra_busy += bsy;
    end
    check("pulses extra done", extra_done, 0);
    check("pulses extra busy", extra_busy, 0);

    // Start held high: second sweep accepted at edge 20, done in cycle 39.
    @(negedge clk);
    if_a.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wait_done(0, 1, at);
    check("held first done", at, 19);
    @(negedge clk);
    get(0, bsy, dn, e, s, m);
    check("held idle gap busy", bsy, 0);
    @(negedge clk);
    get(0, bsy, dn, e, s, m);
    check("held restart busy", bsy, 1);
    check("held restart err_cnt", e, 0);
    check("held restart sum_ed", s, 0);
    if_a.start = 1'b0;
    wait_done(0, 21, at);
    check("held second done", at, 39);
    get(0, bsy, dn, e, s, m);
    check("held second err_cnt", e, 4);
    check("held second sum_ed", s, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
